// File: rtl/mean_pkg.sv
// Shared widths, batch limits, element type and collector state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mean_pkg;
    localparam int IL        = 4;
    localparam int FL        = 16;
    localparam int SIZE      = 16;
    localparam int NUM_W     = 4;
    localparam int MAX_COUNT = 15;

    typedef logic signed [IL+FL-1:0] elem_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/batch_regfile.sv
// Batch storage: SIZE element registers, one indexed write per cycle, clear-all.
// Latency: a write is visible on the cycle after the enabling edge.
// Backpressure: none; the caller decides when to write or clear.
module batch_regfile #(
    parameter int W    = 20,
    parameter int SIZE = 16,
    parameter int AW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W-1:0] wdata,
    input  logic                clr,
    output logic signed [W-1:0] q [SIZE]
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) q[i] <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (clr)
                    q[i] <= '0;
                else if (we && (32'(waddr) == i))
                    q[i] <= wdata;
            end
        end
    end
endmodule

// File: rtl/batch_collect.sv
// Collects fixed-point elements into a batch, pulses start, then holds batch/num until out_ack.
// Latency: closing accept at edge t -> start in cycle t+1, out_valid from t+2. Option: BATCH_COLLECT_LAST_EN adds in_last.
// Backpressure: in_ready is high only while filling; in_valid is ignored otherwise.
module batch_collect #(
    parameter int IL   = mean_pkg::IL,
    parameter int FL   = mean_pkg::FL,
    parameter int SIZE = mean_pkg::SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IL+FL-1:0]      in_data,
`ifdef BATCH_COLLECT_LAST_EN
    input  logic                         in_last,
`endif
    output logic signed [IL+FL-1:0]      batch [SIZE],
    output logic [mean_pkg::NUM_W-1:0]   num,
    output logic                         start,
    output logic                         out_valid,
    input  logic                         out_ack
);
    import mean_pkg::*;

    state_t             state, state_nxt;
    logic               alive;
    logic [NUM_W-1:0]   count;
    logic               accept, close, clr;

    // alive keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    assign in_ready = alive && (state == FILL);
    assign accept   = in_valid && in_ready;

`ifdef BATCH_COLLECT_LAST_EN
    assign close = accept && ((count == NUM_W'(MAX_COUNT - 1)) || in_last);
`else
    assign close = accept && (count == NUM_W'(MAX_COUNT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        out_valid = 1'b0;
        clr       = 1'b0;
        case (state)
            FILL: begin
                if (close) state_nxt = START;
            end
            START: begin
                start     = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ack) begin
                    clr       = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            num   <= '0;
        end else begin
            if (clr) begin
                count <= '0;
                num   <= '0;
            end else if (accept) begin
                count <= count + NUM_W'(1);
            end
            if (state == START) num <= count;
        end
    end

    batch_regfile #(
        .W    (IL + FL),
        .SIZE (SIZE),
        .AW   (NUM_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (count),
        .wdata (in_data),
        .clr   (clr),
        .q     (batch)
    );
endmodule

// File: tb/tb_batch_collect.sv
// Directed bench for batch_collect: fill/close timing, hold, ack, reset, random valid.
module tb_batch_collect;
    localparam int W    = 20;
    localparam int SIZE = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data = '0;
`ifdef BATCH_COLLECT_LAST_EN
    logic                in_last = 1'b0;
`endif
    logic signed [W-1:0] batch [SIZE];
    logic [3:0]          num;
    logic                start;
    logic                out_valid;
    logic                out_ack = 1'b0;

    int ncmp = 0;
    int nerr = 0;

    batch_collect #(.IL(4), .FL(16), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef BATCH_COLLECT_LAST_EN
        .in_last   (in_last),
`endif
        .batch     (batch),
        .num       (num),
        .start     (start),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, required done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one element; returns #1 after the accepting edge with in_valid still high.
    task automatic push(input logic [W-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
`ifdef BATCH_COLLECT_LAST_EN
        in_last  = 1'b0;
`endif
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("push_timeout", 20'(n), 20'(0));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic ack_pulse();
        in_valid = 1'b0;
        out_ack  = 1'b1;
        @(posedge clk); #1;
        out_ack  = 1'b0;
    endtask

    initial begin
        int k;
        int guard;
        logic acc;

        // reset state
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 20'(in_ready), 20'(0));
        chk("rst_out_valid", 20'(out_valid), 20'(0));
        chk("rst_start", 20'(start), 20'(0));
        chk("rst_num", 20'(num), 20'(0));
        chk("rst_batch0", batch[0], 20'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 20'(in_ready), 20'(1));

        // 15 back-to-back elements close the batch
        for (int i = 0; i < 15; i++) push(20'((i + 1) << 16));
        in_valid = 1'b0;
        chk("full_start", 20'(start), 20'(1));
        chk("full_ov_early", 20'(out_valid), 20'(0));
        @(posedge clk); #1;
        chk("full_start_off", 20'(start), 20'(0));
        chk("full_ov", 20'(out_valid), 20'(1));
        chk("full_num", 20'(num), 20'(15));
        for (int i = 0; i < 15; i++) chk($sformatf("full_b%0d", i), batch[i], 20'((i + 1) << 16));
        chk("full_b15", batch[15], 20'h0);

        // in_valid in HOLD is ignored
        in_valid = 1'b1;
        in_data  = 20'h12345;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_ready", 20'(in_ready), 20'(0));
        end
        chk("hold_ov", 20'(out_valid), 20'(1));
        chk("hold_num", 20'(num), 20'(15));
        chk("hold_b0", batch[0], 20'h10000);
        chk("hold_b14", batch[14], 20'hF0000);
        ack_pulse();
        chk("ack_ov", 20'(out_valid), 20'(0));
        chk("ack_num", 20'(num), 20'(0));
        chk("ack_ready", 20'(in_ready), 20'(1));
        for (int i = 0; i < SIZE; i++) chk($sformatf("ack_b%0d", i), batch[i], 20'h0);
        push(20'hABCDE);
        in_valid = 1'b0;
        chk("refill_b0", batch[0], 20'hABCDE);
        chk("refill_b1", batch[1], 20'h0);

        // out_ack during FILL has no effect
        for (int i = 2; i <= 5; i++) push(20'(i));
        ack_pulse();
        chk("fill_ack_ov", 20'(out_valid), 20'(0));
        chk("fill_ack_ready", 20'(in_ready), 20'(1));
        chk("fill_ack_b4", batch[4], 20'h5);
        push(20'h6);
        in_valid = 1'b0;
        chk("fill_ack_b5", batch[5], 20'h6);
        chk("fill_ack_b6", batch[6], 20'h0);
        for (int i = 7; i <= 15; i++) push(20'(i));
        in_valid = 1'b0;
        chk("fill_ack_start", 20'(start), 20'(1));
        @(posedge clk); #1;
        chk("fill_ack_num", 20'(num), 20'(15));
        chk("fill_ack_b14", batch[14], 20'hF);

        // asynchronous reset while holding
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 20'(out_valid), 20'(0));
        chk("arst_num", 20'(num), 20'(0));
        chk("arst_ready", 20'(in_ready), 20'(0));
        for (int i = 0; i < SIZE; i++) chk($sformatf("arst_b%0d", i), batch[i], 20'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready_back", 20'(in_ready), 20'(1));
        push(20'h77777);
        in_valid = 1'b0;
        chk("arst_b0", batch[0], 20'h77777);
        chk("arst_b1", batch[1], 20'h0);
        do_reset();

`ifdef BATCH_COLLECT_LAST_EN
        // early close with in_last
        push(20'h08000);
        push(20'hF8000);
        in_data = 20'h00001;
        in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("last_start", 20'(start), 20'(1));
        @(posedge clk); #1;
        chk("last_start_off", 20'(start), 20'(0));
        chk("last_ov", 20'(out_valid), 20'(1));
        chk("last_num", 20'(num), 20'(3));
        chk("last_b0", batch[0], 20'h08000);
        chk("last_b1", batch[1], 20'hF8000);
        chk("last_b2", batch[2], 20'h00001);
        for (int i = 3; i < SIZE; i++) chk($sformatf("last_b%0d", i), batch[i], 20'h0);
        ack_pulse();
`endif

        // random in_valid: every element lands once, in order
        k = 0;
        guard = 0;
        while (k < 15 && guard < 1000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 20'((k + 1) * 32'h111);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        chk("rand_accepts", 20'(k), 20'(15));
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rand_ov", 20'(out_valid), 20'(1));
        chk("rand_num", 20'(num), 20'(15));
        for (int i = 0; i < 15; i++) chk($sformatf("rand_b%0d", i), batch[i], 20'((i + 1) * 32'h111));
        chk("rand_b15", batch[15], 20'h0);
        ack_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/batch_collect.md
BATCH_COLLECT -- requirements
Module: batch_collect

Interface
REQ-001 SHALL have parameter IL, default 4, meaning integer bits of the fixed-point element.
REQ-002 SHALL have parameter FL, default 16, meaning fraction bits of the fixed-point element.
REQ-003 SHALL have parameter SIZE, default 16, meaning the number of batch entries presented.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the producer offers an element.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an element.
REQ-008 SHALL have port in_data, input, signed IL+FL bits: the offered element.
REQ-009 SHALL have port in_last, input, 1 bit, present only with BATCH_COLLECT_LAST_EN: the offered element closes the batch.
REQ-010 SHALL have port batch, output, SIZE x signed IL+FL bits: the collected elements, index 0 first.
REQ-011 SHALL have port num, output, 4 bits: the count of valid entries.
REQ-012 SHALL have port start, output, 1 bit: a one-cycle pulse that clears the downstream mean accumulator.
REQ-013 SHALL have port out_valid, output, 1 bit: batch and num are stable and complete.
REQ-014 SHALL have port out_ack, input, 1 bit: the consumer has finished with the batch.

Function
REQ-015 SHALL implement states FILL, START and HOLD, with FILL as the reset state.
REQ-016 SHALL drive in_ready=1 only in FILL; the drive depends on state only, never on in_valid.
REQ-017 Accept SHALL occur when in_valid&&in_ready: in_data is written to batch[count] and count increments, with batch visible on the next cycle.
REQ-018 SHALL set MAX_COUNT=15, because num is 4 bits; index 15 stays 0 whenever SIZE=16.
REQ-019 On the accept that brings count to MAX_COUNT, the state SHALL move FILL->START.
REQ-020 In START, the block SHALL drive start=1 for exactly one cycle, latch num=count, then move to HOLD.
REQ-021 In HOLD, the block SHALL drive out_valid=1, keep batch and num constant, and wait for out_ack.
REQ-022 On out_ack in HOLD, the block SHALL move to FILL, zero all batch entries, and set count=0 and num=0.
REQ-023 out_ack in FILL or START SHALL be ignored.
REQ-024 in_valid while in_ready=0 SHALL be ignored, with no accept and no data change.
REQ-025 Timing SHALL be: closing accept at edge t gives start=1 during cycle t+1 and out_valid=1 from cycle t+2.
REQ-026 Batch entries at index >= num SHALL read 0 whenever out_valid=1.
REQ-027 There SHALL be no arithmetic: elements are stored bit-exact, and num is count truncated to 4 bits (max 15).

Reset
REQ-028 Asserting rst_n=0 at any time, including mid-FILL or mid-HOLD, SHALL immediately set state=FILL, count=0, num=0, all batch=0, start=0, out_valid=0 and in_ready=0.
REQ-029 in_ready SHALL rise in the first cycle after rst_n deasserts; a partially collected batch is discarded.

Configuration
REQ-030 With BATCH_COLLECT_LAST_EN defined, the in_last port SHALL exist, and an accept with in_last=1 closes the batch (FILL->START) at count 1..15.
REQ-031 Without BATCH_COLLECT_LAST_EN, in_last SHALL be absent and batches close only at MAX_COUNT.

Structure
REQ-032 Package mean_pkg SHALL hold IL, FL, SIZE, NUM_W=4, MAX_COUNT=15, the element typedef and the state enum.
REQ-033 Storage SHALL be a sub-module batch_regfile: SIZE registers with indexed write enable and synchronous clear-all, reset asynchronously.

Verification
REQ-034 The bench SHALL stream 15 elements 0x10000..0xF0000 back-to-back -> start pulse on the cycle after the 15th accept, num=15, batch[i]=(i+1)<<16, batch[15]=0, out_valid held.
REQ-035 The bench SHALL test with LAST_EN: 3 elements 0x08000, 0xF8000, 0x00001 with last on the 3rd -> num=3, batch[3..15]=0, start for one cycle.
REQ-036 The bench SHALL hold in_valid=1 in HOLD with in_data=0x12345 -> in_ready=0, batch unchanged; out_ack -> FILL, all entries 0, first accept lands at index 0.
REQ-037 The bench SHALL assert out_ack during FILL after 5 accepts -> no effect; count continues to 6.
REQ-038 The bench SHALL assert rst_n=0 in HOLD with num=15 -> out_valid=0, num=0, batch all 0 immediately; next batch collects from index 0.
REQ-039 The bench SHALL toggle in_valid randomly for 15 elements -> accepts only on in_valid&&in_ready, no element duplicated or dropped.
